// File: rtl/config_chain_loader_if.sv
// Word handshake between a bitstream source and the configuration chain loader.
// The source drives word_in/word_valid; the loader answers with word_ready.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Serialises configuration words MSB-first onto the head of the tile config chain.
// Stops after exactly CHAIN_LENGTH shifted bits and reports completion/truncation.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 16,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                 config_clock,
  input  logic                 config_nreset,
  input  logic                 start,
  input  logic                 abort,
  config_chain_loader_if.slave word_bus,
  output logic                 chain_data,
  output logic                 chain_enable,
  output logic [CNT_WIDTH-1:0] bits_loaded,
  output logic                 busy,
  output logic                 done,
  output logic                 truncated
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [WORD_WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [CNT_WIDTH-1:0]  bits_q;
  logic                  trunc_q;

  logic last_chain_bit;
  logic last_word_bit;
  logic ready_cond;
  logic accept;

  assign last_chain_bit = (bits_q == CNT_WIDTH'(CHAIN_LENGTH - 1));
  assign last_word_bit  = (bit_idx_q == '0);

  // Ready on the final bit of a word lets the next word follow without a bubble;
  // it is withheld on the final chain bit so no word is swallowed at completion.
  assign ready_cond = (state_q == S_WAIT_WORD) ||
                      ((state_q == S_SHIFT) && last_word_bit && !last_chain_bit);
  assign word_bus.word_ready = ready_cond && !abort;
  assign accept              = word_bus.word_ready && word_bus.word_valid;

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      bits_q    <= '0;
      trunc_q   <= 1'b0;
    end else if (abort) begin
      // bits_loaded is left intact so software can see how far the load got
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_WAIT_WORD;
            bits_q  <= '0;
            trunc_q <= 1'b0;
          end
        end
        S_WAIT_WORD: begin
          if (accept) begin
            shreg_q   <= word_bus.word_in;
            bit_idx_q <= IDX_W'(WORD_WIDTH - 1);
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg_q   <= shreg_q << 1;
          bit_idx_q <= bit_idx_q - IDX_W'(1);
          if (bits_q != CNT_WIDTH'(CHAIN_LENGTH))
            bits_q <= bits_q + CNT_WIDTH'(1);
          if (last_chain_bit) begin
            state_q <= S_DONE;
            trunc_q <= !last_word_bit;
          end else if (last_word_bit) begin
            if (accept) begin
              shreg_q   <= word_bus.word_in;
              bit_idx_q <= IDX_W'(WORD_WIDTH - 1);
            end else begin
              state_q <= S_WAIT_WORD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign chain_enable = (state_q == S_SHIFT);
  assign chain_data   = shreg_q[WORD_WIDTH-1];
  assign bits_loaded  = bits_q;
  assign busy         = (state_q == S_WAIT_WORD) || (state_q == S_SHIFT);
  assign done         = (state_q == S_DONE);
  assign truncated    = trunc_q;

endmodule
